nbcac_8di_decoder_seq: RTL and testbench
========================================

Name: nbcac_8di_decoder_seq

Overview:
Multi-cycle decoder for the 8-bit-data, 11-wire NBCAC codeword. It sits directly downstream of the 8-bit NBCAC encoder core, on the receive side of the bus. It accepts one 11-bit codeword d[11:1] per valid/ready transaction and reconstructs the 8-bit data by weighted bit accumulation, one codeword bit per cycle. It flags codewords whose weighted sum exceeds the 8-bit range.

Parameters:
CW_W, 11, codeword width; fixed at 11 for the 8-bit code.
DATA_W, 8, decoded data width.
SAT_ON_ERR, 1, 1 = saturate data_out to 255 on overflow; 0 = output the low 8 bits of the sum.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous reset, active-high
cw_in  input  11  codeword; bit k-1 carries d[k], k = 1..11
cw_valid  input  1  codeword present
cw_ready  output  1  decoder can accept a codeword
data_out  output  8  decoded data
data_err  output  1  weighted sum > 255; qualified by data_valid
data_valid  output  1  result present
data_ready  input  1  consumer accepts result

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Weights w[1..11] = 1, 110, 68, 42, 26, 16, 10, 6, 4, 2, 2.
  - Decoded value = sum over k of d[k]*w[k].
  - Maximum possible sum is 287.
  - Accumulator is 9 bits unsigned and never wraps internally.
- States:
  - IDLE: cw_ready=1. On cw_valid&cw_ready at an edge: latch cw_in into cw_reg, clear acc, set idx=1, go to ACC.
  - ACC: each edge does acc += cw_reg[idx-1] ? w[idx] : 0 and idx++. The edge that processes idx=11 goes to DONE. ACC lasts exactly 11 cycles; zero bits are not skipped.
  - DONE: data_valid=1. On data_valid&data_ready go to IDLE.
- DONE outputs:
  - data_err = (acc > 255).
  - data_out = acc[7:0] when acc ≤ 255.
  - On overflow: data_out = 8'hFF if SAT_ON_ERR=1, else acc[7:0].
- Timing:
  - Acceptance at edge E0; data_valid rises after edge E11.
  - cw_ready=0 in ACC and DONE. The cycle in which DONE is consumed cannot also accept a new codeword.
  - Maximum throughput is one codeword per 13 cycles.
- Handshake rules:
  - data_out and data_err are stable and held while data_valid=1 && data_ready=0.
  - data_ready is ignored outside DONE.
  - cw_in and cw_valid are ignored outside IDLE.
  - cw_in is sampled only at the accept edge; later changes have no effect.
- Reset:
  - rst high at any edge, including mid-ACC or in DONE: state←IDLE, acc←0, idx←0, cw_reg←0, data_out←0, data_err←0, data_valid←0.
  - cw_ready=1 in the first cycle after reset release.
  - An in-flight result is discarded, not delivered.
  - If rst and cw_valid are both high at the same edge, reset wins and nothing is accepted.
- Codeword checking: no forbidden-pattern check. Any 11-bit value is decoded; overflow is the only reported error.

Test Plan:
- Reset then cw_in=11'h000 with valid → data_valid high 11 cycles after the accept edge; data_out=0, data_err=0.
- cw_in=11'h71F (encoder image of 255) → data_out=255, data_err=0. Also cw_in=11'h001 → 1, and cw_in=11'h00C → 110.
- cw_in=11'h7FF (sum 287) → data_err=1. data_out=8'hFF with SAT_ON_ERR=1; data_out=8'h1F with SAT_ON_ERR=0.
- Hold data_ready=0 for 5 cycles in DONE → data_out and data_valid held constant and cw_ready=0. Then data_ready=1 → IDLE next cycle, cw_ready=1. A codeword offered during DONE is not accepted until IDLE.
- Assert rst at the 6th ACC cycle → all outputs 0 next cycle and no data_valid pulse. A following codeword 11'h00C decodes to 110.
- Exhaustive loop: encode v=0..255 with the encoder core and feed each codeword back-to-back with data_ready=1 → each data_out==v, data_err=0, spacing 13 cycles per result.

Source files
------------

// File: rtl/nbcac_8di_decoder_seq.sv
// ---------------------------------------------------------------------------
// nbcac_8di_decoder_seq
//
// Receive-side decoder for the 8-bit-data, 11-wire NBCAC codeword. It accepts
// one codeword per valid/ready transaction. It then rebuilds the data value by
// accumulating one weighted codeword bit per cycle. It reports codewords whose
// weighted sum does not fit in DATA_W bits.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   cw_in      in   codeword, bit k-1 carries d[k] (k = 1..11)
//   cw_valid   in   codeword present
//   cw_ready   out  decoder can accept a codeword (IDLE only)
//   data_out   out  decoded data, held while data_valid && !data_ready
//   data_err   out  weighted sum exceeded 255, qualified by data_valid
//   data_valid out  result present
//   data_ready in   consumer accepts the result
//
// Latency: the accept edge is E0, and data_valid rises after E11. The DONE
// cycle cannot also accept a codeword, so the decoder takes at most one
// codeword every 13 cycles.
// ---------------------------------------------------------------------------
module nbcac_8di_decoder_seq #(
  parameter int CW_W       = 11,
  parameter int DATA_W     = 8,
  parameter int SAT_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_W-1:0]   cw_in,
  input  logic              cw_valid,
  output logic              cw_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_err,
  output logic              data_valid,
  input  logic              data_ready
);

  // One extra bit holds the worst-case sum (287), so the accumulator never wraps.
  localparam int ACC_W = DATA_W + 1;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_W);
  localparam logic [ACC_W-1:0] DATA_MAX = {1'b0, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW_W-1:0]    cw_q;
  logic [ACC_W-1:0]   acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  dout_q;
  logic               derr_q;
  logic               dvld_q;

  logic [CW_W-1:0]    cw_shift;
  logic               cur_bit;
  logic [ACC_W-1:0]   acc_nxt;
  logic               accept;
  logic               last;

  // Weight of codeword position k (1-based). Positions outside 1..11 add nothing.
  function automatic logic [ACC_W-1:0] weight(input logic [IDX_W-1:0] k);
    case (k)
      4'd1:    weight = ACC_W'(1);
      4'd2:    weight = ACC_W'(110);
      4'd3:    weight = ACC_W'(68);
      4'd4:    weight = ACC_W'(42);
      4'd5:    weight = ACC_W'(26);
      4'd6:    weight = ACC_W'(16);
      4'd7:    weight = ACC_W'(10);
      4'd8:    weight = ACC_W'(6);
      4'd9:    weight = ACC_W'(4);
      4'd10:   weight = ACC_W'(2);
      4'd11:   weight = ACC_W'(2);
      default: weight = '0;
    endcase
  endfunction

  // On overflow: clamp to all ones when saturating, otherwise keep the low bits.
  function automatic logic [DATA_W-1:0] fmt_out(input logic [ACC_W-1:0] s);
    if ((s > DATA_MAX) && (SAT_ON_ERR != 0))
      fmt_out = {DATA_W{1'b1}};
    else
      fmt_out = s[DATA_W-1:0];
  endfunction

  // Select cw_q[idx_q-1] with a shift, so the index never goes out of range.
  assign cw_shift = cw_q >> (idx_q - 4'd1);
  assign cur_bit  = cw_shift[0];
  assign acc_nxt  = acc_q + (cur_bit ? weight(idx_q) : '0);
  assign accept   = (state_q == S_IDLE) && cw_valid;
  assign last     = (state_q == S_ACC) && (idx_q == LAST_IDX);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cw_valid)              state_d = S_ACC;
      S_ACC:   if (idx_q == LAST_IDX)     state_d = S_DONE;
      S_DONE:  if (data_ready)            state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    cw_ready   = (state_q == S_IDLE);
    data_valid = dvld_q;
    data_out   = dout_q;
    data_err   = derr_q;
  end

  // ---- datapath: capture, accumulate, publish ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q   <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      dout_q <= '0;
      derr_q <= 1'b0;
      dvld_q <= 1'b0;
    end else begin
      if (accept) begin
        cw_q  <= cw_in;
        acc_q <= '0;
        idx_q <= 4'd1;
      end else if (state_q == S_ACC) begin
        acc_q <= acc_nxt;
        idx_q <= idx_q + 4'd1;
      end
      // The final sum is published on the same edge that adds the last bit.
      if (last) begin
        dout_q <= fmt_out(acc_nxt);
        derr_q <= (acc_nxt > DATA_MAX);
        dvld_q <= 1'b1;
      end else if ((state_q == S_DONE) && data_ready) begin
        dvld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nbcac_8di_decoder_seq.sv
module tb_nbcac_8di_decoder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] cw_in;
  logic        cw_valid;
  logic        data_ready;

  logic        cw_ready,  cw_ready0;
  logic [7:0]  data_out,  data_out0;
  logic        data_err,  data_err0;
  logic        data_valid, data_valid0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nbcac_8di_decoder_seq #(.CW_W(11), .DATA_W(8), .SAT_ON_ERR(1)) dut (
    .clk(clk), .rst(rst), .cw_in(cw_in), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .data_out(data_out), .data_err(data_err), .data_valid(data_valid),
    .data_ready(data_ready)
  );

  nbcac_8di_decoder_seq #(.CW_W(11), .DATA_W(8), .SAT_ON_ERR(0)) dut0 (
    .clk(clk), .rst(rst), .cw_in(cw_in), .cw_valid(cw_valid), .cw_ready(cw_ready0),
    .data_out(data_out0), .data_err(data_err0), .data_valid(data_valid0),
    .data_ready(data_ready)
  );

  typedef struct {
    logic [10:0] cw;
    logic [7:0]  exp_out;   // SAT_ON_ERR = 1
    logic [7:0]  exp_out0;  // SAT_ON_ERR = 0
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Greedy encoder: it yields a codeword with weighted sum v for any v in 0..287.
  // Each weight is at most one more than the sum of all the smaller weights.
  function automatic logic [10:0] encode(input int v);
    int w[12];
    int order[11];
    int rem;
    logic [10:0] c;
    w[0] = 0;  w[1] = 1;  w[2] = 110; w[3] = 68; w[4] = 42; w[5] = 26;
    w[6] = 16; w[7] = 10; w[8] = 6;   w[9] = 4;  w[10] = 2; w[11] = 2;
    order[0] = 2; order[1] = 3; order[2] = 4;  order[3] = 5;  order[4] = 6; order[5] = 7;
    order[6] = 8; order[7] = 9; order[8] = 10; order[9] = 11; order[10] = 1;
    rem = v;
    c = '0;
    for (int i = 0; i < 11; i++) begin
      if (rem >= w[order[i]]) begin
        rem = rem - w[order[i]];
        c[order[i]-1] = 1'b1;
      end
    end
    return c;
  endfunction

  // One full transaction with data_ready held high. On entry the caller is in IDLE.
  task automatic run_cw(input string tag, input logic [10:0] cw, input logic [7:0] eo,
                        input logic [7:0] eo0, input logic ee, output int t_valid);
    int n;
    data_ready = 1'b1;
    cw_in      = cw;
    cw_valid   = 1'b1;
    check({tag, " cw_ready before accept"}, cw_ready, 1);
    tick();                       // accept edge E0
    cw_valid = 1'b0;
    cw_in    = ~cw;               // later changes must not matter
    n = 0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
    t_valid = cyc;
    check({tag, " latency"}, n, 11);
    check({tag, " data_out"}, data_out, eo);
    check({tag, " data_err"}, data_err, ee);
    check({tag, " data_out nosat"}, data_out0, eo0);
    check({tag, " data_err nosat"}, data_err0, ee);
    tick();                       // consume edge
    check({tag, " valid after consume"}, data_valid, 0);
    check({tag, " cw_ready after consume"}, cw_ready, 1);
  endtask

  initial begin
    int t, t_prev, n;
    bit seen;

    vecs[0] = '{11'h000, 8'd0,   8'd0,   1'b0};
    vecs[1] = '{11'h001, 8'd1,   8'd1,   1'b0};
    vecs[2] = '{11'h00C, 8'd110, 8'd110, 1'b0};
    vecs[3] = '{11'h71F, 8'd255, 8'd255, 1'b0};
    vecs[4] = '{11'h7FF, 8'hFF,  8'h1F,  1'b1};  // 287
    vecs[5] = '{11'h3FF, 8'hFF,  8'h1D,  1'b1};  // 285
    vecs[6] = '{11'h400, 8'd2,   8'd2,   1'b0};
    vecs[7] = '{11'h700, 8'd8,   8'd8,   1'b0};

    rst = 1'b1; cw_in = '0; cw_valid = 1'b0; data_ready = 1'b0;
    tick(); tick();
    check("reset data_valid", data_valid, 0);
    check("reset data_out", data_out, 0);
    check("reset data_err", data_err, 0);
    check("reset cw_ready", cw_ready, 1);

    // Reset wins over a codeword offered at the same edge.
    cw_in = 11'h001; cw_valid = 1'b1;
    tick();
    rst = 1'b0; cw_valid = 1'b0;
    check("rst+valid cw_ready", cw_ready, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (data_valid) seen = 1;
    end
    check("rst+valid no result", seen, 0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++)
      run_cw($sformatf("vec%0d", i), vecs[i].cw, vecs[i].exp_out, vecs[i].exp_out0,
             vecs[i].exp_err, t);

    // Backpressure in DONE; a codeword offered then must wait for IDLE.
    data_ready = 1'b0;
    cw_in = 11'h00C; cw_valid = 1'b1;
    tick();
    cw_valid = 1'b0;
    n = 0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp latency", n, 11);
    cw_in = 11'h001; cw_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp data_valid held", data_valid, 1);
      check("bp data_out held", data_out, 110);
      check("bp data_err held", data_err, 0);
      check("bp cw_ready low", cw_ready, 0);
    end
    data_ready = 1'b1;
    tick();
    check("bp consumed", data_valid, 0);
    check("bp idle cw_ready", cw_ready, 1);
    tick();                       // codeword 001 accepted only now
    cw_valid = 1'b0;
    n = 0;
    while (!data_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp next latency", n, 11);
    check("bp next data_out", data_out, 1);
    tick();

    // Reset during the 6th ACC cycle discards the result.
    cw_in = 11'h7FF; cw_valid = 1'b1;
    tick();                       // accept
    cw_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst data_valid", data_valid, 0);
    check("midrst data_out", data_out, 0);
    check("midrst data_err", data_err, 0);
    check("midrst cw_ready", cw_ready, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (data_valid) seen = 1;
      tick();
    end
    check("midrst no result", seen, 0);
    run_cw("after midrst", 11'h00C, 8'd110, 8'd110, 1'b0, t);

    // Exhaustive back-to-back decode.
    t_prev = 0;
    for (int v = 0; v < 256; v++) begin
      run_cw($sformatf("exh%0d", v), encode(v), 8'(v), 8'(v), 1'b0, t);
      if (v > 0) check($sformatf("exh%0d spacing", v), t - t_prev, 13);
      t_prev = t;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
